// File: rtl/insight_sink_arbiter.sv
// Round-robin arbiter sharing one Insight sink channel among NREQ sources via a one-entry
// registered output stage. Optional stall watchdog enabled by INSIGHT_ARB_STALL_WDOG_EN.
module insight_sink_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_sink,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    output logic                    out_sink,
    input  logic                    out_ready,
    output logic [$clog2(NREQ)-1:0] out_src,
    output logic                    stall,
    input  logic                    stall_clr
);

    localparam int unsigned SW = $clog2(NREQ);

    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] grant_idx;
    logic [SW-1:0] ptr_next;
    logic          grant_found;
    logic          load;

    // The output stage can take a new beat when empty or when its beat leaves this cycle.
    assign load = !out_valid || out_ready;

    always_comb begin
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_found && req_valid[SW'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = SW'(idx);
            end
        end
    end

    always_comb begin
        ptr_next = grant_idx + SW'(1);
        if (grant_idx == SW'(NREQ - 1)) begin
            ptr_next = '0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (load && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_sink  <= 1'b0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (grant_found) begin
                out_valid <= 1'b1;
                out_sink  <= req_sink[grant_idx];
                out_src   <= grant_idx;
                rr_ptr    <= ptr_next;
            end else begin
                // Payload holds its last value when the stage drains.
                out_valid <= 1'b0;
            end
        end
    end

`ifdef INSIGHT_ARB_STALL_WDOG_EN
    logic [15:0] wdog_cnt;
    logic        stall_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt <= '0;
            stall_q  <= 1'b0;
        end else if (stall_clr) begin
            wdog_cnt <= '0;
            stall_q  <= 1'b0;
        end else begin
            if (wdog_cnt >= 16'(STALL_LIMIT)) begin
                stall_q <= 1'b1;
            end
            if (out_valid && !out_ready) begin
                if (wdog_cnt != 16'hffff) begin
                    wdog_cnt <= wdog_cnt + 16'd1;
                end
            end else begin
                wdog_cnt <= '0;
            end
        end
    end

    assign stall = stall_q;
`else
    logic unused_stall_clr;
    assign unused_stall_clr = stall_clr;
    assign stall            = 1'b0;
`endif

endmodule

// File: tb/tb_insight_sink_arbiter.sv
// Scoreboard bench for insight_sink_arbiter: a grant model pushes expected beats, a monitor
// pops and compares them when the output stage hands a beat to the consumer.
module tb_insight_sink_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned LIMIT = 8;
    localparam int unsigned SW    = $clog2(NREQ);

    typedef struct {
        int unsigned src;
        bit          sink;
    } beat_t;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_sink;
    logic [NREQ-1:0] req_ready;
    logic            out_valid;
    logic            out_sink;
    logic            out_ready;
    logic [SW-1:0]   out_src;
    logic            stall;
    logic            stall_clr;

    int unsigned checks = 0;
    int unsigned errors = 0;

    beat_t       exp_q[$];
    int unsigned ptr_m  = 0;
    bit          full_m = 0;
    int unsigned wait_m[NREQ];
    int unsigned cnt_m  = 0;
    bit          stall_m = 0;

    insight_sink_arbiter #(
        .NREQ       (NREQ),
        .STALL_LIMIT(LIMIT)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_sink (req_sink),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_sink (out_sink),
        .out_ready(out_ready),
        .out_src  (out_src),
        .stall    (stall),
        .stall_clr(stall_clr)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] s, input logic r,
                         input logic c);
        @(posedge clock);
        #1;
        req_valid = v;
        req_sink  = s;
        out_ready = r;
        stall_clr = c;
    endtask

    // Monitor: output stage contents, consumption and the stall flag.
    always @(negedge clock) begin
        bit  fullb;
        bit  exp_stall;
        if (!reset_n) begin
            cnt_m   = 0;
            stall_m = 0;
        end else begin
            fullb = (exp_q.size() != 0);
            check("out_valid", out_valid, fullb);
            if (out_valid && out_ready && fullb) begin
                beat_t b;
                b = exp_q.pop_front();
                check("out_src", out_src, b.src);
                check("out_sink", out_sink, b.sink);
            end
`ifdef INSIGHT_ARB_STALL_WDOG_EN
            exp_stall = stall_m;
`else
            exp_stall = 1'b0;
`endif
            check("stall", stall, exp_stall);
            if (stall_clr) begin
                stall_m = 0;
                cnt_m   = 0;
            end else begin
                if (cnt_m >= LIMIT) stall_m = 1;
                if (fullb && !out_ready) cnt_m = (cnt_m < 65535) ? cnt_m + 1 : cnt_m;
                else cnt_m = 0;
            end
        end
    end

    // Reference model: round-robin grant from the position after the last winner.
    always @(negedge clock) begin
        #1;
        if (!reset_n) begin
            exp_q.delete();
            ptr_m  = 0;
            full_m = 0;
            for (int i = 0; i < NREQ; i++) wait_m[i] = 0;
        end else begin
            int              g;
            logic [NREQ-1:0] exp_rdy;
            g       = -1;
            exp_rdy = '0;
            if (!full_m || out_ready) begin
                for (int k = 0; k < NREQ; k++) begin
                    int unsigned i;
                    i = (ptr_m + k) % NREQ;
                    if (g < 0 && req_valid[i]) g = int'(i);
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", req_ready, exp_rdy);
            if (g >= 0) begin
                beat_t b;
                b.src  = g;
                b.sink = req_sink[g];
                exp_q.push_back(b);
                ptr_m = (g + 1) % NREQ;
                for (int i = 0; i < NREQ; i++) begin
                    if (i == g || !req_valid[i]) begin
                        wait_m[i] = 0;
                    end else begin
                        wait_m[i]++;
                        check("fairness_wait", wait_m[i] < NREQ, 1);
                    end
                end
            end
            full_m = (g >= 0) || (full_m && !out_ready);
        end
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_sink  = '0;
        out_ready = 1'b0;
        stall_clr = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sink", out_sink, 0);
        check("rst_out_src", out_src, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_stall", stall, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // All requesters busy, consumer always ready: 0,1,2,3,0,... every cycle.
        repeat (12) drive('1, 4'b1010, 1'b1, 1'b0);
        repeat (2) drive('0, '0, 1'b1, 1'b0);

        // Only requester 2 with sink=1 while the consumer stalls.
        repeat (6) drive(4'b0100, 4'b0100, 1'b0, 1'b0);
        repeat (2) drive('0, '0, 1'b1, 1'b0);

        // Move the pointer to 2, then requesters 1 and 3 compete: 3 wins first, then 1.
        drive(4'b0010, '0, 1'b1, 1'b0);
        drive('0, '0, 1'b1, 1'b0);
        repeat (2) drive(4'b1010, 4'b1000, 1'b1, 1'b0);
        repeat (2) drive('0, '0, 1'b1, 1'b0);

        // Reset while holding a beat under back-pressure.
        drive(4'b0001, 4'b0001, 1'b1, 1'b0);
        repeat (2) drive('0, '0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_src", out_src, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) drive('0, '0, 1'b1, 1'b0);

        // Watchdog: hold a beat for ten stalled cycles, then clear.
        drive(4'b1000, '0, 1'b1, 1'b0);
        repeat (11) drive('0, '0, 1'b0, 1'b0);
        #3;
`ifdef INSIGHT_ARB_STALL_WDOG_EN
        check("wdog_stall_set", stall, 1);
`else
        check("wdog_stall_off", stall, 0);
`endif
        drive('0, '0, 1'b0, 1'b1);
        drive('0, '0, 1'b0, 1'b0);
        #3;
        check("wdog_stall_clr", stall, 0);
        repeat (2) drive('0, '0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 10000; n++) begin
            drive(NREQ'($urandom), NREQ'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 63) == 0));
        end
        repeat (3) drive('0, '0, 1'b1, 1'b0);
        @(negedge clock);
        #2;
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
